// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: data-memory initiator with word/byte access, read-modify-write byte stores and error reporting
module dm_access_ctrl #(
    parameter int ADDR_W    = 16,
    parameter int MEM_WORDS = 8192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic              req_signext,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              resp_valid,
    output logic [15:0]       resp_rdata,
    output logic              resp_err,
    output logic [15:0]       A_DataAddress,
    output logic [15:0]       D_WriteData,
    output logic              C_DMRead,
    output logic              C_DMWrite,
    input  logic [15:0]       D_Data
);
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, ERR} state_t;
    state_t state, state_nx;
    logic              l_write, l_byte, l_sext, l_lane;
    logic [7:0]        l_wbyte;
    logic [ADDR_W-2:0] widx;
    logic              acc, bad;
    logic [7:0]        rbyte;
    assign widx      = req_addr[ADDR_W-1:1];
    assign acc       = req_valid && req_ready;
    assign bad       = (!req_byte && req_addr[0]) || (32'(widx) >= MEM_WORDS);
    assign req_ready = state == IDLE;
    assign C_DMRead  = state == RD;
    assign C_DMWrite = state == WR;
    assign rbyte     = l_lane ? D_Data[15:8] : D_Data[7:0];
    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;
    // next-state: only byte stores leave CAP for WR
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !acc ? IDLE : bad ? ERR : (req_write && !req_byte) ? WR : RD;
            RD:      state_nx = CAP;
            CAP:     state_nx = l_write ? WR : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // request latching, memory address/data and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid    <= 1'b0;
            resp_err      <= 1'b0;
            resp_rdata    <= '0;
            A_DataAddress <= '0;
            D_WriteData   <= '0;
            l_write       <= 1'b0;
            l_byte        <= 1'b0;
            l_sext        <= 1'b0;
            l_lane        <= 1'b0;
            l_wbyte       <= '0;
        end else begin
            resp_valid <= (state == CAP && !l_write) || state == WR || state == ERR;
            if (acc) begin
                l_write       <= req_write;
                l_byte        <= req_byte;
                l_sext        <= req_signext;
                l_lane        <= req_addr[0];
                l_wbyte       <= req_wdata[7:0];
                A_DataAddress <= 16'({1'b0, widx});
                if (req_write && !req_byte && !bad)
                    D_WriteData <= req_wdata;
            end
            if (state == CAP && !l_write) begin
                resp_rdata <= l_byte ? {{8{l_sext & rbyte[7]}}, rbyte} : D_Data;
                resp_err   <= 1'b0;
            end
            if (state == CAP && l_write)
                D_WriteData <= l_lane ? {l_wbyte, D_Data[7:0]} : {D_Data[15:8], l_wbyte};
            if (state == WR || state == ERR) begin
                resp_rdata <= '0;
                resp_err   <= state == ERR;
            end
        end
    end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: directed and randomized checks of dm_access_ctrl against a word-array memory model
module tb_dm_access_ctrl;
    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_ready, req_write = 0, req_byte = 0, req_signext = 0;
    logic [15:0] req_addr = 0, req_wdata = 0;
    logic        resp_valid, resp_err, C_DMRead, C_DMWrite;
    logic [15:0] resp_rdata, A_DataAddress, D_WriteData;
    logic [15:0] D_Data = 0;
    logic [15:0] mem     [0:8191];
    logic [15:0] ref_mem [0:8191];
    int tests = 0, fails = 0, wr_count = 0;

    dm_access_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_byte(req_byte), .req_signext(req_signext),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .A_DataAddress(A_DataAddress),
        .D_WriteData(D_WriteData), .C_DMRead(C_DMRead), .C_DMWrite(C_DMWrite),
        .D_Data(D_Data)
    );

    always #5 clk = ~clk;

    // data memory: read data appears the cycle after a sampled read strobe
    always @(posedge clk) begin
        if (C_DMRead) D_Data <= mem[A_DataAddress[12:0]];
        if (C_DMWrite) begin
            mem[A_DataAddress[12:0]] <= D_WriteData;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_load(input logic b, input logic s, input logic [15:0] a);
        int w, v;
        w = int'(ref_mem[a / 2]);
        if (!b) return 16'(w);
        v = (w >> (8 * (a % 2))) % 256;
        if (s && v >= 128) v += 'hFF00;
        return 16'(v);
    endfunction

    task automatic req(input string tag, input logic w, input logic b, input logic s,
                       input logic [15:0] a, input logic [15:0] wd);
        int widx, lat, rds, wrs, ew;
        logic e;
        logic [15:0] exp_d, exp_wd, wa, wdat;
        widx = int'(a) / 2;
        e = (!b && a[0]) || widx >= 8192;
        exp_d = (e || w) ? 16'h0 : ref_load(b, s, a);
        exp_wd = 0;
        if (!e && w) begin
            ew = int'(ref_mem[widx]);
            exp_wd = !b ? wd : a[0] ? 16'((ew % 256) + (int'(wd) % 256) * 256)
                                    : 16'((ew / 256) * 256 + int'(wd) % 256);
            ref_mem[widx] = exp_wd;
        end
        @(negedge clk);
        chk({tag, "_ready"}, req_ready, 1);
        req_write = w; req_byte = b; req_signext = s; req_addr = a; req_wdata = wd; req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0; req_write = $urandom; req_byte = $urandom; req_addr = 16'($urandom);
        lat = 0; rds = 0; wrs = 0; wa = 0; wdat = 0;
        while (!resp_valid && lat < 10) begin
            chk({tag, "_excl"}, C_DMRead && C_DMWrite, 0);
            rds += int'(C_DMRead);
            if (C_DMWrite) begin wrs++; wa = A_DataAddress; wdat = D_WriteData; end
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, e ? 1 : !w ? 2 : b ? 3 : 1);
        chk({tag, "_rds"}, rds, (!e && (!w || b)) ? 1 : 0);
        chk({tag, "_wrs"}, wrs, (!e && w) ? 1 : 0);
        if (!e && w) begin
            chk({tag, "_waddr"}, wa, widx);
            chk({tag, "_wdata"}, wdat, exp_wd);
        end
        chk({tag, "_rdata"}, resp_rdata, exp_d);
        chk({tag, "_err"}, resp_err, e);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, resp_valid, 0);
        chk({tag, "_hold"}, {resp_err, resp_rdata}, {e, exp_d});
    endtask

    initial begin
        logic [15:0] bb_exp [3];
        int wc;
        for (int i = 0; i < 8192; i++) begin mem[i] = 0; ref_mem[i] = 0; end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {resp_valid, resp_err, resp_rdata, A_DataAddress, D_WriteData, C_DMRead, C_DMWrite},
            0);
        chk("rst_ready", req_ready, 1);
        rst = 0;

        req("wst", 1, 0, 0, 16'h0010, 16'h1234);
        req("wld", 0, 0, 0, 16'h0010, 0);
        chk("wld_val", resp_rdata, 16'h1234);

        mem[5] = 16'hA1B2; ref_mem[5] = 16'hA1B2;
        req("bld_hs", 0, 1, 1, 16'h000B, 0);
        chk("bld_hs_val", resp_rdata, 16'hFFA1);
        req("bld_hz", 0, 1, 0, 16'h000B, 0);
        chk("bld_hz_val", resp_rdata, 16'h00A1);
        req("bld_ls", 0, 1, 1, 16'h000A, 0);
        chk("bld_ls_val", resp_rdata, 16'hFFB2);
        req("bst", 1, 1, 0, 16'h000A, 16'h5A0C);
        req("bst_rb", 0, 0, 0, 16'h000A, 0);
        chk("bst_rb_val", resp_rdata, 16'hA10C);

        req("err_mis", 0, 0, 0, 16'h0003, 0);
        req("err_oor", 0, 1, 0, 16'h4000, 0);
        req("err_wst", 1, 0, 0, 16'hC000, 16'hBEEF);

        for (int k = 0; k < 3; k++) begin
            mem[20 + k] = 16'h7000 + 16'(k * 17); ref_mem[20 + k] = mem[20 + k];
            bb_exp[k] = ref_load(0, 0, 16'(40 + 2 * k));
        end
        @(negedge clk);
        req_write = 0; req_byte = 0; req_addr = 16'd40; req_valid = 1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            chk("bb_rd_ready", req_ready, 0);
            chk("bb_rd_pulse", resp_valid, 0);
            if (k < 2) req_addr = 16'(42 + 2 * k);
            @(posedge clk); #1;
            chk("bb_cap_ready", req_ready, 0);
            @(posedge clk); #1;
            chk("bb_resp", resp_valid, 1);
            chk("bb_rdata", resp_rdata, bb_exp[k]);
            chk("bb_idle_ready", req_ready, 1);
            if (k == 2) req_valid = 0;
            @(posedge clk); #1;
        end
        chk("bb_done", {resp_valid, req_ready}, 2'b01);

        mem[5] = 16'hA1B2; ref_mem[5] = 16'hA1B2;
        @(negedge clk);
        req_write = 1; req_byte = 1; req_addr = 16'h000A; req_wdata = 16'h5A77; req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0;
        chk("rst_rd_strobe", C_DMRead, 1);
        wc = wr_count;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("rst_ab_ready", req_ready, 1);
        for (int i = 0; i < 4; i++) begin
            chk("rst_ab_quiet", {C_DMWrite, resp_valid}, 0);
            @(posedge clk); #1;
        end
        chk("rst_ab_wrcount", wr_count, wc);
        chk("rst_ab_mem", mem[5], 16'hA1B2);
        req("rst_ab_rb", 0, 0, 0, 16'h000A, 0);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            a = ($urandom % 8 == 0) ? 16'(16'h4000 + $urandom % 16'hC000) : 16'($urandom_range(0, 31));
            req("rnd", 1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Initiator side of the data-memory interface.
- Accepts byte-addressed load/store requests from the execute stage over a valid/ready handshake.
- Drives the word-addressed data memory strobes (C_DMRead, C_DMWrite), address and write data, and captures D_Data.
- Supports word and byte access: byte stores use read-modify-write; byte loads return zero- or sign-extended data. Misaligned and out-of-range requests are reported as errors.

Parameters:
ADDR_W, 16, width of the request byte address and of A_DataAddress.
MEM_WORDS, 8192, number of 16-bit words in the data memory; word index >= MEM_WORDS is out of range.

Ports:
clk  input  1  clock; all state changes on posedge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  controller can accept; high only in IDLE.
req_write  input  1  1 = store, 0 = load.
req_byte  input  1  1 = byte access, 0 = word access.
req_signext  input  1  byte load only: 1 = sign-extend, 0 = zero-extend.
req_addr  input  ADDR_W  byte address.
req_wdata  input  16  store data; a byte store uses [7:0].
resp_valid  output  1  one-cycle completion pulse.
resp_rdata  output  16  load result; 0 for stores and errors.
resp_err  output  1  valid with resp_valid; misaligned or out-of-range.
A_DataAddress  output  16  word address to data memory.
D_WriteData  output  16  write data to data memory.
C_DMRead  output  1  memory read strobe.
C_DMWrite  output  1  memory write strobe.
D_Data  input  16  memory read data; valid the cycle after the edge that sampled C_DMRead=1.

Behaviour:
- Reset (rst high at posedge): state=IDLE; resp_valid=0; resp_err=0; resp_rdata=0; A_DataAddress=0; D_WriteData=0; C_DMRead=0; C_DMWrite=0.
- Reset takes priority over everything. An aborted operation produces no response. No C_DMWrite is issued after the reset edge.
- Accept: at a posedge with req_valid & req_ready. Request fields are latched; they are ignored otherwise.
- Address mapping: word index = req_addr[ADDR_W-1:1]; A_DataAddress = {1'b0, word index}.
- Byte lanes are little-endian: addr[0]=0 selects [7:0]; addr[0]=1 selects [15:8].
- Error: word access with addr[0]=1, or word index >= MEM_WORDS. The request goes IDLE->ERR. C_DMRead and C_DMWrite are never asserted.
- States (strobes are registered and valid during the state):
  - IDLE: strobes 0. Dispatch: error -> ERR; word store -> WR; any load or byte store -> RD.
  - RD: C_DMRead=1; next CAP.
  - CAP: D_Data is valid.
    - Load: resp_rdata <= extracted/extended data; resp_valid <= 1; next IDLE.
    - Byte store: D_WriteData <= D_Data with the selected byte replaced by wdata[7:0]; next WR.
  - WR: C_DMWrite=1, D_WriteData stable; at exit resp_valid <= 1, resp_rdata <= 0; next IDLE.
  - ERR: resp_valid <= 1, resp_err <= 1, resp_rdata <= 0; next IDLE.
- Latency, with acceptance at edge N:
  - Load: resp_valid high after edge N+2.
  - Word store: after N+1 (memory write at N+1).
  - Byte store: after N+3 (memory write at N+3).
  - Error: after N+1.
- resp_valid lasts exactly one cycle. resp_rdata and resp_err hold until the next response.
- A new request is accepted in the same cycle resp_valid is high (back-to-back allowed).
- C_DMRead and C_DMWrite are never high in the same cycle.
- A_DataAddress and D_WriteData hold their last values while idle.
- Byte load extension:
  - signext=1 -> {8{byte[7]}, byte}.
  - signext=0 -> {8'h00, byte}.
  - req_signext is ignored for word loads and all stores.

Test Plan:
- Word store addr 0x0010 data 0x1234, then word load 0x0010 -> C_DMWrite high one cycle with A_DataAddress=0x0008 and D_WriteData=0x1234; store resp after N+1; load resp_rdata=0x1234 after N+2, resp_err=0.
- Preload word 5=0xA1B2. Byte load 0x000B signext=1 -> 0xFFA1. Byte load 0x000B signext=0 -> 0x00A1. Byte load 0x000A signext=1 -> 0xFFB2.
- Byte store 0x5A0C to 0x000A (word 5=0xA1B2) -> C_DMRead one cycle, then C_DMWrite one cycle with D_WriteData=0xA10C; resp after N+3. A following word load 0x000A returns 0xA10C.
- Error cases:
  - Word load 0x0003 -> no strobes; resp_valid with resp_err=1 and resp_rdata=0x0000 after N+1.
  - Byte load 0x4000 (word 8192) -> resp_err=1.
- Back-to-back: req_valid held high with three word loads -> accepts spaced 3 cycles apart; three resp_valid pulses with correct data; req_ready low during RD/CAP.
- rst high for one edge during the RD cycle of a byte store to word 5 -> no C_DMWrite, no resp_valid, req_ready=1 next cycle, word 5 unchanged (0xA1B2).
